// File: rtl/pcie_us_rc_tag_router.sv
// Tag ownership table and routing control for the UltraScale PCIe RC
// completion demultiplexer. Hands out non-posted tags to requesters in
// round-robin order. Routes each completion to its owner by its tag. Frees
// a tag when the first beat of a completion marks its request complete.
module pcie_us_rc_tag_router #(
  parameter int M_COUNT   = 2,
  parameter int TAG_WIDTH = 8,
  parameter int TAG_COUNT = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [M_COUNT-1:0]             s_alloc_valid,
  output logic [M_COUNT-1:0]             s_alloc_ready,
  output logic [TAG_WIDTH-1:0]           s_alloc_tag,
  input  logic [95:0]                    rc_tdata,
  input  logic                           rc_tvalid,
  input  logic                           rc_tready,
  input  logic                           rc_tlast,
  input  logic [TAG_WIDTH-1:0]           rc_tag,
  output logic [M_COUNT-1:0]             select,
  output logic                           drop,
  output logic                           enable,
  output logic [$clog2(TAG_COUNT+1)-1:0] in_flight,
  output logic                           err_unexpected
);

  localparam int CL_M_COUNT = $clog2(M_COUNT);
  localparam int OWNER_W    = (CL_M_COUNT > 0) ? CL_M_COUNT : 1;
  localparam int IDX_W      = ($clog2(TAG_COUNT) > 0) ? $clog2(TAG_COUNT) : 1;
  localparam int CNT_W      = $clog2(TAG_COUNT+1);

  // Registered state
  logic [TAG_COUNT-1:0] tag_valid_q, tag_valid_d;
  logic [OWNER_W-1:0]   owner_q [TAG_COUNT];
  logic [OWNER_W-1:0]   owner_d;
  logic [IDX_W-1:0]     alloc_ptr_q, alloc_ptr_d;
  logic [OWNER_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic                 frame_q, frame_d;
  logic [CNT_W-1:0]     in_flight_q, in_flight_d;
  logic                 enable_q, enable_d;
  logic                 err_unexpected_q, err_unexpected_d;

  // Combinational decisions
  logic                 grant;
  logic [OWNER_W-1:0]   winner;
  logic [2*M_COUNT-1:0] req_rot;
  int                   win_off;
  logic                 first_beat;
  logic                 rel_req;
  logic [TAG_WIDTH-1:0] rel_tag;
  logic                 rel_hit;
  logic [IDX_W-1:0]     rel_idx;
  logic                 lookup_hit;

  // Only the tag field, the request-completed bit and tlast matter here.
  logic unused_tdata;
  assign unused_tdata = ^{rc_tdata[95:64+TAG_WIDTH], rc_tdata[63:31], rc_tdata[29:0]};

  // Owner lookup for the demux; must be zero-latency off registered state
  // because the demux samples select on the first beat.
  always_comb begin
    lookup_hit = 1'b0;
    if (32'(rc_tag) < 32'(TAG_COUNT)) begin
      lookup_hit = tag_valid_q[rc_tag[IDX_W-1:0]];
    end
    select = '0;
    if (lookup_hit) begin
      select = M_COUNT'(1) << owner_q[rc_tag[IDX_W-1:0]];
    end
    drop = !lookup_hit;
  end

  // Round-robin pick among requesters, starting the search at rr_ptr.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    req_rot = {s_alloc_valid, s_alloc_valid} >> rr_ptr_q;
    win_off = 0;
    for (int i = M_COUNT - 1; i >= 0; i--) begin
      if (req_rot[i]) win_off = i;
    end
    winner = OWNER_W'((int'(rr_ptr_q) + win_off) % M_COUNT);
    grant  = enable_q && !tag_valid_q[alloc_ptr_q] && (|s_alloc_valid);
    s_alloc_ready = grant ? (M_COUNT'(1) << winner) : '0;
    s_alloc_tag   = TAG_WIDTH'(alloc_ptr_q);
  end

  // Frame tracking and completion-driven release decode.
  always_comb begin
    first_beat = rc_tvalid && rc_tready && !frame_q;
    rel_req    = first_beat && rc_tdata[30];
    rel_tag    = rc_tdata[64 +: TAG_WIDTH];
    rel_idx    = rel_tag[IDX_W-1:0];
    rel_hit    = 1'b0;
    if (32'(rel_tag) < 32'(TAG_COUNT)) begin
      rel_hit = rel_req && tag_valid_q[rel_idx];
    end
    frame_d = frame_q;
    if (rc_tvalid && rc_tready) begin
      frame_d = !rc_tlast;
    end
  end

  // Next-state for the table, pointers and counters.
  always_comb begin
    tag_valid_d      = tag_valid_q;
    owner_d          = winner;
    alloc_ptr_d      = alloc_ptr_q;
    rr_ptr_d         = rr_ptr_q;
    enable_d         = 1'b1;
    err_unexpected_d = rel_req && !rel_hit;
    // A grant and a release never hit the same tag: a grant needs the entry
    // free, a release needs it held.
    if (grant) begin
      tag_valid_d[alloc_ptr_q] = 1'b1;
      rr_ptr_d = OWNER_W'((int'(winner) + 1) % M_COUNT);
    end
    if (rel_hit) begin
      tag_valid_d[rel_idx] = 1'b0;
    end
    // Advance after a grant, or scan past an entry that is held.
    if (grant || tag_valid_q[alloc_ptr_q]) begin
      alloc_ptr_d = (alloc_ptr_q == IDX_W'(TAG_COUNT - 1)) ? '0 : alloc_ptr_q + IDX_W'(1);
    end
    in_flight_d = in_flight_q + CNT_W'(grant) - CNT_W'(rel_hit);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid_q      <= '0;
      alloc_ptr_q      <= '0;
      rr_ptr_q         <= '0;
      frame_q          <= 1'b0;
      in_flight_q      <= '0;
      enable_q         <= 1'b0;
      err_unexpected_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      tag_valid_q      <= tag_valid_d;
      alloc_ptr_q      <= alloc_ptr_d;
      rr_ptr_q         <= rr_ptr_d;
      frame_q          <= frame_d;
      in_flight_q      <= in_flight_d;
      enable_q         <= enable_d;
      err_unexpected_q <= err_unexpected_d;
    end
  end

  // Owner table write on grant.
  // NOTE: owner entries are read only when tag_valid is set, so this array
  // carries no reset.
  always_ff @(posedge clk) begin
    if (grant) begin
      owner_q[alloc_ptr_q] <= owner_d;
    end
  end

  assign enable         = enable_q;
  assign in_flight      = in_flight_q;
  assign err_unexpected = err_unexpected_q;

endmodule

// File: tb/tb_pcie_us_rc_tag_router.sv
// Self-checking bench for pcie_us_rc_tag_router: directed scenarios followed
// by randomized traffic, all compared against a behavioural table model.
module tb_pcie_us_rc_tag_router;

  localparam int M  = 2;
  localparam int TW = 8;
  localparam int TC = 32;
  localparam int CW = $clog2(TC+1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [M-1:0]  s_alloc_valid;
  logic [M-1:0]  s_alloc_ready;
  logic [TW-1:0] s_alloc_tag;
  logic [95:0]   rc_tdata;
  logic          rc_tvalid;
  logic          rc_tready;
  logic          rc_tlast;
  logic [TW-1:0] rc_tag;
  logic [M-1:0]  select;
  logic          drop;
  logic          enable;
  logic [CW-1:0] in_flight;
  logic          err_unexpected;

  pcie_us_rc_tag_router #(.M_COUNT(M), .TAG_WIDTH(TW), .TAG_COUNT(TC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_alloc_valid (s_alloc_valid),
    .s_alloc_ready (s_alloc_ready),
    .s_alloc_tag   (s_alloc_tag),
    .rc_tdata      (rc_tdata),
    .rc_tvalid     (rc_tvalid),
    .rc_tready     (rc_tready),
    .rc_tlast      (rc_tlast),
    .rc_tag        (rc_tag),
    .select        (select),
    .drop          (drop),
    .enable        (enable),
    .in_flight     (in_flight),
    .err_unexpected(err_unexpected)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: a table of who holds which tag, a scan pointer, and
  // the round-robin start point.
  bit            m_valid [TC];
  int            m_owner [TC];
  int            m_ptr;
  int            m_rr;
  bit            m_frame;
  bit            m_en;
  bit            m_err;
  logic [M-1:0]  obs_ready;
  logic [TW-1:0] obs_tag;

  task automatic model_reset();
    for (int i = 0; i < TC; i++) m_valid[i] = 1'b0;
    m_ptr = 0; m_rr = 0; m_frame = 1'b0; m_en = 1'b0; m_err = 1'b0;
  endtask

  task automatic idle();
    s_alloc_valid = '0;
    rc_tvalid = 1'b0; rc_tready = 1'b1; rc_tlast = 1'b0;
    rc_tdata = '0; rc_tag = '0;
  endtask

  // One clock: check outputs at the falling edge, advance the model, then
  // return just after the rising edge so the caller can drive new inputs.
  task automatic step();
    int           winner = -1;
    int           cnt = 0;
    int           rel = -1;
    int           t;
    logic [M-1:0] exp_ready = '0;
    logic [M-1:0] exp_sel = '0;
    logic         exp_drop = 1'b1;
    @(negedge clk);
    if (m_en && !m_valid[m_ptr]) begin
      for (int k = 0; k < M; k++) begin
        int c = (m_rr + k) % M;
        if (winner < 0 && s_alloc_valid[c]) winner = c;
      end
    end
    if (winner >= 0) exp_ready = M'(1) << winner;
    if (int'(rc_tag) < TC) begin
      if (m_valid[int'(rc_tag)]) begin
        exp_sel  = M'(1) << m_owner[int'(rc_tag)];
        exp_drop = 1'b0;
      end
    end
    for (int i = 0; i < TC; i++) cnt += int'(m_valid[i]);
    check("ready",     64'(s_alloc_ready),  64'(exp_ready));
    check("alloc_tag", 64'(s_alloc_tag),    64'(m_ptr));
    check("select",    64'(select),         64'(exp_sel));
    check("drop",      64'(drop),           64'(exp_drop));
    check("enable",    64'(enable),         64'(m_en));
    check("in_flight", 64'(in_flight),      64'(cnt));
    check("err",       64'(err_unexpected), 64'(m_err));
    obs_ready = s_alloc_ready;
    obs_tag   = s_alloc_tag;
    m_err = 1'b0;
    if (rc_tvalid && rc_tready) begin
      if (!m_frame && rc_tdata[30]) begin
        t = int'(rc_tdata[71:64]);
        if (t < TC && m_valid[t]) rel = t;
        else m_err = 1'b1;
      end
      m_frame = !rc_tlast;
    end
    if (winner >= 0) begin
      m_valid[m_ptr] = 1'b1;
      m_owner[m_ptr] = winner;
      m_rr  = (winner + 1) % M;
      m_ptr = (m_ptr + 1) % TC;
    end else if (m_valid[m_ptr]) begin
      m_ptr = (m_ptr + 1) % TC;
    end
    if (rel >= 0) m_valid[rel] = 1'b0;
    m_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int tag, input bit complete, input bit last);
    rc_tvalid = 1'b1; rc_tready = 1'b1; rc_tlast = last;
    rc_tdata = {$urandom, $urandom, $urandom};
    rc_tdata[71:64] = 8'(tag);
    rc_tdata[30] = complete;
    step();
    rc_tvalid = 1'b0; rc_tlast = 1'b0;
  endtask

  // Assert reset between edges with whatever inputs are live, check the
  // outputs drop to reset values at once, then release.
  task automatic do_reset();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("rst_ready",     64'(s_alloc_ready),  64'(0));
    check("rst_tag",       64'(s_alloc_tag),    64'(0));
    check("rst_in_flight", 64'(in_flight),      64'(0));
    check("rst_enable",    64'(enable),         64'(0));
    check("rst_err",       64'(err_unexpected), 64'(0));
    check("rst_select",    64'(select),         64'(0));
    check("rst_drop",      64'(drop),           64'(1));
    model_reset();
    idle();
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst_n = 1'b0;
    idle();
    model_reset();
    do_reset();

    // Single requester gets three consecutive tags.
    step();
    check("s1_enable", 64'(enable), 64'(1));
    s_alloc_valid = 2'b01;
    repeat (3) step();
    s_alloc_valid = '0;
    check("s1_in_flight", 64'(in_flight), 64'(3));

    // Two requesters alternate; lookup of tag 3 routes to port 1.
    do_reset();
    step();
    s_alloc_valid = 2'b11;
    repeat (4) step();
    s_alloc_valid = '0;
    rc_tag = 8'd3;
    #1;
    check("s2_select", 64'(select), 64'(2'b10));
    check("s2_drop",   64'(drop),   64'(0));
    step();
    check("s2_in_flight", 64'(in_flight), 64'(4));

    // Two-beat completion: only the first beat releases.
    beat(1, 1'b1, 1'b0);
    check("s3_after_first", 64'(in_flight), 64'(3));
    beat(2, 1'b1, 1'b1);
    check("s3_after_second", 64'(in_flight), 64'(3));

    // Out-of-range lookup and release of an unallocated tag.
    rc_tag = 8'd40;
    step();
    check("s4_drop", 64'(drop), 64'(1));
    beat(5, 1'b1, 1'b1);
    #1;
    check("s4_err_pulse", 64'(err_unexpected), 64'(1));
    step();
    check("s4_err_clear", 64'(err_unexpected), 64'(0));
    check("s4_in_flight", 64'(in_flight), 64'(3));

    // Fill the table, free tag 17, and expect it to come back.
    s_alloc_valid = 2'b11;
    repeat (40) step();
    check("s5_full", 64'(in_flight), 64'(32));
    s_alloc_valid = '0;
    beat(17, 1'b1, 1'b1);
    check("s5_freed", 64'(in_flight), 64'(31));
    s_alloc_valid = 2'b01;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (obs_ready != '0) found = 1'b1;
    end
    check("s5_regrant_seen", 64'(found), 64'(1));
    check("s5_regrant_tag", 64'(obs_tag), 64'(17));
    s_alloc_valid = '0;

    // Asynchronous reset mid-frame with ten tags outstanding.
    do_reset();
    step();
    s_alloc_valid = 2'b01;
    repeat (10) step();
    s_alloc_valid = '0;
    check("s6_in_flight", 64'(in_flight), 64'(10));
    beat(3, 1'b0, 1'b0);
    rc_tvalid = 1'b1; rc_tag = 8'd3; s_alloc_valid = 2'b11;
    do_reset();
    step();
    rc_tag = 8'd3;
    step();
    beat(3, 1'b1, 1'b1);
    step();
    check("s6_after_in_flight", 64'(in_flight), 64'(0));

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      s_alloc_valid = ($urandom_range(0, 3) == 0) ? '0 : M'($urandom_range(0, 3));
      rc_tvalid = 1'($urandom_range(0, 1));
      rc_tready = ($urandom_range(0, 3) != 0);
      rc_tlast  = ($urandom_range(0, 2) == 0);
      rc_tdata  = {$urandom, $urandom, $urandom};
      rc_tdata[71:64] = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, TC-1))
                                                     : 8'($urandom_range(0, 255));
      rc_tdata[30] = ($urandom_range(0, 3) != 0);
      rc_tag = ($urandom_range(0, 3) != 0) ? 8'($urandom_range(0, TC-1))
                                            : 8'($urandom_range(0, 255));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pcie_us_rc_tag_router.md
Name: pcie_us_rc_tag_router

Overview:
Tag ownership table and routing control for the Ultrascale PCIe RC completion demultiplexer. Requesters (DMA engines, one per demux output) obtain non-posted tags here. The block drives the demux select/drop/enable from the tag field of each completion's first beat. It snoops the RC stream at the demux input and frees a tag when a completion marks its request complete.

Parameters:
M_COUNT, 2, number of requesters / demux outputs
TAG_WIDTH, 8, tag field width (RC descriptor tdata[71:64])
TAG_COUNT, 32, tags managed (0..TAG_COUNT-1); must be <= 2**TAG_WIDTH
CL_M_COUNT, $clog2(M_COUNT), owner index width (derived; override prohibited)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
s_alloc_valid  in  M_COUNT  per-requester tag request
s_alloc_ready  out  M_COUNT  grant; at most one bit set per cycle
s_alloc_tag  out  TAG_WIDTH  tag granted (valid with any ready bit)
rc_tdata  in  96  snoop of RC stream tdata[95:0] at demux input
rc_tvalid  in  1  snoop tvalid
rc_tready  in  1  snoop tready (demux s_axis_rc_tready)
rc_tlast  in  1  snoop tlast
rc_tag  in  TAG_WIDTH  tag from demux requester_id output
select  out  M_COUNT  one-hot owner of rc_tag
drop  out  1  rc_tag unknown or out of range
enable  out  1  demux enable
in_flight  out  $clog2(TAG_COUNT+1)  allocated tag count
err_unexpected  out  1  one-cycle pulse: release of unallocated tag

Behaviour:
- Reset (async assert, sync release): tag_valid all 0, alloc_ptr=0, rr_ptr=0, frame_reg=0, in_flight=0, enable=0, err_unexpected=0, s_alloc_ready=0.
- enable: register, 1 from the first edge after reset release.
- Table: tag_valid[TAG_COUNT] and owner[TAG_COUNT] (CL_M_COUNT bits each). Flops, not RAM.
- Lookup is combinational from registered state:
  - If rc_tag < TAG_COUNT and tag_valid[rc_tag]: select = 1<<owner[rc_tag], drop=0.
  - Otherwise: select=0, drop=1.
  - Zero added latency, because the demux samples select on the first beat.
- Allocation:
  - s_alloc_tag = alloc_ptr.
  - If !tag_valid[alloc_ptr] and any s_alloc_valid: grant the round-robin winner starting at rr_ptr. Set ready only for that bit.
  - On grant: set tag_valid, store owner, alloc_ptr increments (wraps TAG_COUNT-1 -> 0), rr_ptr = winner+1 mod M_COUNT, in_flight+1.
  - If tag_valid[alloc_ptr]=1: no grant; alloc_ptr advances one per cycle (scan), regardless of requests.
  - Table full: ready stays 0, pointer keeps scanning.
- Frame tracking:
  - Beat = rc_tvalid && rc_tready.
  - First beat = beat with frame_reg=0. frame_reg=1 after a non-last beat, 0 after a tlast beat.
- Release: on a first beat with rc_tdata[30] (request completed) = 1, tag t = rc_tdata[71:64].
  - If t<TAG_COUNT and tag_valid[t]: clear at that edge, in_flight-1.
  - Otherwise: pulse err_unexpected next cycle, table unchanged.
  - Non-first beats never release.
- Simultaneous events:
  - Release and grant on different tags in the same cycle: both take effect; in_flight unchanged.
  - Release of the tag at alloc_ptr: no grant that cycle (registered valid still 1); ptr advances as in a scan.
  - Lookup for a tag released this cycle still returns the old owner (registered).
- Reset mid-operation: all tags freed, outstanding completions arriving afterwards -> drop=1, err_unexpected pulses on their release.

Test Plan:
- Reset release, s_alloc_valid=2'b01 held 3 cycles -> grants tags 0,1,2 to port 0 on consecutive cycles; in_flight=3; enable=1.
- Both ports request continuously -> grants alternate port 0,1,0,1 with tags 0,1,2,3; rc_tag=3 -> select=2'b10, drop=0.
- Release: 2-beat completion, first beat tdata[71:64]=1, tdata[30]=1 -> tag 1 freed after beat 1, in_flight 4->3; tdata[30]=1 on beat 2 with tag 2 -> no release.
- Fill all 32 tags -> ready stays 0. Release tag 17 -> after at most 32 scan cycles, the next grant returns tag 17.
- rc_tag=40 -> drop=1, select=0; release of tag 5 when not allocated -> err_unexpected single-cycle pulse, in_flight unchanged.
- rst_n asserted asynchronously mid-frame with 10 tags in flight -> all outputs at reset values immediately; after release, in_flight=0 and any rc_tag -> drop=1.
